// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the 5-stage MIPS core.
// The write-back control bundle is also produced by the write-back control decode.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Register-file write enable with $zero protection.
  function automatic logic wb_write_ok(input logic reg_write, input logic [REG_AW-1:0] rd);
    return reg_write & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_data_mux.sv
// Write-back data select (load data vs ALU result) with $zero write suppression.
// Shared with the forwarding unit.
module wb_data_mux
  import pipe_pkg::*;
(
  input  wb_ctrl_t          ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] load_data,
  input  logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] wdata_c,
  output logic              we_c
);

  assign wdata_c = ctrl.mem_to_reg ? load_data : alu_result;
  assign we_c    = wb_write_ok(ctrl.reg_write, rd);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registered write-back port, forwarding tap, and
// load-response stall with timeout for variable-latency data memory.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              err_clr,
  output logic              stall_out,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  wb_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] pend_rd;
  logic              pend_reg_write;
  logic [DATA_W-1:0] pend_alu;

  logic              is_load_c;
  logic              timeout_c;
  logic              capture_c;
  wb_ctrl_t          mux_ctrl;
  logic [DATA_W-1:0] mux_alu;
  logic [REG_AW-1:0] mux_rd;
  logic [DATA_W-1:0] mux_wdata_c;
  logic              mux_we_c;

  assign is_load_c = in_valid & in_mem_to_reg;

  // The cycle in which the wait counter would reach TIMEOUT_CYCLES gives up on the load.
  assign timeout_c = (state == WAIT_MEM) & ~mem_rvalid & (cnt >= CNT_LAST);

  always_comb begin
    capture_c = 1'b0;
    stall_out = 1'b0;
    case (state)
      RUN: begin
        capture_c = in_valid & (~in_mem_to_reg | mem_rvalid);
        stall_out = is_load_c & ~mem_rvalid;
      end
      WAIT_MEM: begin
        capture_c = mem_rvalid;
        stall_out = ~mem_rvalid & ~timeout_c;
      end
      default: begin
        capture_c = 1'b0;
        stall_out = 1'b0;
      end
    endcase
    // Keep upstream moving while reset is held; the pending load is discarded.
    if (rst) stall_out = 1'b0;
  end

  // In WAIT_MEM the in_* bus is ignored; the latched load drives the write-back.
  always_comb begin
    mux_ctrl = '{reg_write: in_reg_write, mem_to_reg: in_mem_to_reg};
    mux_alu  = in_alu_result;
    mux_rd   = in_rd;
    if (state == WAIT_MEM) begin
      mux_ctrl = '{reg_write: pend_reg_write, mem_to_reg: 1'b1};
      mux_alu  = pend_alu;
      mux_rd   = pend_rd;
    end
  end

  wb_data_mux u_mux (
    .ctrl       (mux_ctrl),
    .alu_result (mux_alu),
    .load_data  (mem_rdata),
    .rd         (mux_rd),
    .wdata_c    (mux_wdata_c),
    .we_c       (mux_we_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      cnt            <= '0;
      pend_rd        <= '0;
      pend_reg_write <= 1'b0;
      pend_alu       <= '0;
      wb_we          <= 1'b0;
      wb_waddr       <= '0;
      wb_wdata       <= '0;
      mem_err        <= 1'b0;
    end else begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      if (capture_c) begin
        wb_we    <= mux_we_c;
        wb_waddr <= mux_rd;
        wb_wdata <= mux_wdata_c;
      end

      if (timeout_c)    mem_err <= 1'b1;
      else if (err_clr) mem_err <= 1'b0;

      case (state)
        RUN: begin
          if (is_load_c && !mem_rvalid) begin
            state          <= WAIT_MEM;
            cnt            <= CNT_ONE;
            pend_rd        <= in_rd;
            pend_reg_write <= in_reg_write;
            pend_alu       <= in_alu_result;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid || timeout_c) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign fwd_valid = wb_we;
  assign fwd_rd    = wb_waddr;
  assign fwd_data  = wb_wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues expected write-backs,
// a negedge monitor pops and compares whenever wb_we is seen.
module tb_mem_wb_stage;

  localparam int unsigned TO = 16;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        err_clr = 1'b0;
  logic        stall_out, wb_we, fwd_valid, mem_err;
  logic [4:0]  wb_waddr, fwd_rd;
  logic [31:0] wb_wdata, fwd_data;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t m_e;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result), .in_rd(in_rd),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err_clr(err_clr),
    .stall_out(stall_out), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [4:0] rd, input logic rv, input logic [31:0] rdata);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
    in_alu_result = alu; in_rd = rd; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    err_clr = 1'b0;
  endtask

  // Present a load whose response arrives after n_wait stalled cycles
  // (n_wait >= TO means it never arrives). Ends just after the capture/timeout edge.
  task automatic do_load(input logic [4:0] rd, input logic [31:0] data, input int n_wait,
                         input logic clr);
    int stalls = 0;
    int exp_stalls;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, rd, 1'b0, 32'h0);
    err_clr = clr;
    for (int i = 0; i < 40; i++) begin
      if (i == n_wait) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      #1;
      if (!stall_out) break;
      stalls++;
      tick();
      in_rd = ~rd;
      in_alu_result = 32'hBAD0_0000;
    end
    exp_stalls = (n_wait < int'(TO)) ? n_wait : int'(TO) - 1;
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (n_wait < int'(TO) && rd != 5'd0) sb.push_back('{rd: rd, data: data});
    tick();
    idle();
  endtask

  // Monitor: every write-back must match the oldest expected entry; fwd mirrors wb.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_we || fwd_valid) begin
          chk("fwd_valid", 32'(fwd_valid), 32'(wb_we));
          chk("fwd_rd", 32'(fwd_rd), 32'(wb_waddr));
          chk("fwd_data", fwd_data, wb_wdata);
        end
        if (wb_we) begin
          if (sb.size() == 0) begin
            chk("unexpected_wb_we", 32'(wb_waddr), 32'hFFFF_FFFF);
          end else begin
            m_e = sb.pop_front();
            chk("wb_waddr", 32'(wb_waddr), 32'(m_e.rd));
            chk("wb_wdata", wb_wdata, m_e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tick();
    tick();
    chk("rst_wb_we", 32'(wb_we), 32'h0);
    chk("rst_wb_waddr", 32'(wb_waddr), 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_fwd", {fwd_valid, fwd_rd, fwd_data[25:0]}, 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_mem_err", 32'(mem_err), 32'h0);
    rst = 1'b0;
    tick();

    // ALU write, then back-to-back zero-wait load
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1234, 5'd8, 1'b0, 32'h0);
    sb.push_back('{rd: 5'd8, data: 32'h0000_1234});
    #1 chk("alu_stall", 32'(stall_out), 32'h0);
    tick();
    do_load(5'd9, 32'hDEAD_BEEF, 0, 1'b0);

    // 3-cycle load; in_rd is changed during the wait and must be ignored
    do_load(5'd10, 32'hCAFE_F00D, 3, 1'b0);
    chk("load3_mem_err", 32'(mem_err), 32'h0);

    // Bubble, $zero ALU, $zero load, reg_write=0: no writes
    tick();
    chk("bubble_we", 32'(wb_we), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0);
    tick();
    chk("zero_alu_we", 32'(wb_we), 32'h0);
    do_load(5'd0, 32'h1111_2222, 0, 1'b0);
    chk("zero_load_we", 32'(wb_we), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0077, 5'd5, 1'b0, 32'h0);
    tick();
    chk("rw0_we", 32'(wb_we), 32'h0);
    idle();

    // Longest successful wait: response on the last allowed cycle
    do_load(5'd14, 32'h0BAD_F00D, int'(TO) - 1, 1'b0);
    chk("boundary_mem_err", 32'(mem_err), 32'h0);

    // Timeout: sticky error, dropped write, then clear
    do_load(5'd11, 32'h0, 100, 1'b0);
    chk("timeout_mem_err", 32'(mem_err), 32'h1);
    chk("timeout_we", 32'(wb_we), 32'h0);
    tick();
    tick();
    chk("mem_err_sticky", 32'(mem_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(mem_err), 32'h0);

    // Timeout with err_clr held: set wins
    do_load(5'd12, 32'h0, 100, 1'b1);
    chk("set_wins", 32'(mem_err), 32'h1);

    // Reset in the 2nd WAIT_MEM cycle
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0800, 5'd12, 1'b0, 32'h0);
    tick();
    tick();
    chk("wait_stall", 32'(stall_out), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall_out), 32'h0);
    chk("midrst_mem_err", 32'(mem_err), 32'h0);
    chk("midrst_wb", {wb_we, wb_waddr, wb_wdata[25:0]}, 32'h0);
    chk("midrst_fwd", {fwd_valid, fwd_rd, fwd_data[25:0]}, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h5555_AAAA);
    tick();
    chk("late_rvalid_we", 32'(wb_we), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_00C3, 5'd13, 1'b0, 32'h0);
    sb.push_back('{rd: 5'd13, data: 32'h0000_00C3});
    tick();
    chk("post_rst_we", 32'(wb_we), 32'h1);
    idle();
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
